// File: rtl/core_pkg.sv
// Shared core definitions: functional-unit encoding and default tag widths.
// Imported by the dispatch stage and its busy table.
package core_pkg;

    localparam int PREG_WIDTH_DEF = 7;
    localparam int ROB_WIDTH_DEF  = 4;

    typedef enum logic [1:0] {
        FU_ALU  = 2'd0,
        FU_LSU  = 2'd1,
        FU_BRU  = 2'd2,
        FU_NONE = 2'd3
    } fu_type_e;

    // FU_NONE goes straight to the ROB, so it never waits on a reservation station.
    function automatic logic target_ready(input fu_type_e fu, input logic alu_rdy,
                                          input logic lsu_rdy, input logic bru_rdy);
        case (fu)
            FU_ALU:  return alu_rdy;
            FU_LSU:  return lsu_rdy;
            FU_BRU:  return bru_rdy;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/busy_table.sv
// Physical-register busy bits: one set port (rename), one clear port (writeback),
// two read ports that see a same-cycle clear but not a same-cycle set.
module busy_table
    import core_pkg::*;
#(
    parameter int PREG_WIDTH = PREG_WIDTH_DEF,
    parameter int NUM_PREGS  = 2**PREG_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  set_en,
    input  logic [PREG_WIDTH-1:0] set_preg,
    input  logic                  clr_en,
    input  logic [PREG_WIDTH-1:0] clr_preg,
    input  logic [PREG_WIDTH-1:0] rd_preg0,
    input  logic [PREG_WIDTH-1:0] rd_preg1,
    output logic                  rd_busy0,
    output logic                  rd_busy1
);

    logic [NUM_PREGS-1:0] busy_q;
    logic [NUM_PREGS-1:0] busy_d;

    // Set is applied after clear so a new producer wins over a stale writeback.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) busy_d[clr_preg] = 1'b0;
        if (set_en) busy_d[set_preg] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) busy_q <= '0;
        else       busy_q <= busy_d;
    end

    assign rd_busy0 = busy_q[rd_preg0] && !(clr_en && clr_preg == rd_preg0);
    assign rd_busy1 = busy_q[rd_preg1] && !(clr_en && clr_preg == rd_preg1);

endmodule

// File: rtl/dispatch_stage.sv
// Dispatch stage: a single holding register between rename and the reservation
// stations / ROB, with source-readiness capture from the busy table.
module dispatch_stage
    import core_pkg::*;
#(
    parameter int PREG_WIDTH = PREG_WIDTH_DEF,
    parameter int ROB_WIDTH  = ROB_WIDTH_DEF,
    parameter int NUM_PREGS  = 2**PREG_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rename_valid,
    input  logic [PREG_WIDTH-1:0] rename_prs1,
    input  logic [PREG_WIDTH-1:0] rename_prs2,
    input  logic [PREG_WIDTH-1:0] rename_prd,
    input  logic [PREG_WIDTH-1:0] rename_old_prd,
    input  logic [ROB_WIDTH-1:0]  rename_rob_tag,
    input  logic                  rename_reg_write,
    input  logic [1:0]            rename_fu_type,
    output logic                  dispatch_ready,
    output logic                  rs_alu_valid,
    output logic                  rs_lsu_valid,
    output logic                  rs_bru_valid,
    input  logic                  rs_alu_ready,
    input  logic                  rs_lsu_ready,
    input  logic                  rs_bru_ready,
    output logic [PREG_WIDTH-1:0] out_prs1,
    output logic [PREG_WIDTH-1:0] out_prs2,
    output logic [PREG_WIDTH-1:0] out_prd,
    output logic [ROB_WIDTH-1:0]  out_rob_tag,
    output logic                  out_prs1_rdy,
    output logic                  out_prs2_rdy,
    output logic                  out_reg_write,
    output logic                  rob_alloc_valid,
    output logic [PREG_WIDTH-1:0] rob_old_prd,
    input  logic                  rob_full,
    input  logic                  wb_valid,
    input  logic [PREG_WIDTH-1:0] wb_preg,
    input  logic                  branch_mispredict
);

    logic                  hold_valid;
    fu_type_e              h_fu;
    logic [PREG_WIDTH-1:0] h_prs1, h_prs2, h_prd, h_old_prd;
    logic [ROB_WIDTH-1:0]  h_rob_tag;
    logic                  h_reg_write, h_prs1_rdy, h_prs2_rdy;

    logic fire, accept, set_en, busy1, busy2;

    assign fire = hold_valid && !branch_mispredict && !rob_full
                && target_ready(h_fu, rs_alu_ready, rs_lsu_ready, rs_bru_ready);
    assign dispatch_ready = !branch_mispredict && (!hold_valid || fire);
    assign accept = rename_valid && dispatch_ready;
    assign set_en = accept && rename_reg_write && (rename_prd != '0);

    busy_table #(.PREG_WIDTH(PREG_WIDTH), .NUM_PREGS(NUM_PREGS)) u_busy (
        .clk      (clk),
        .reset    (reset),
        .set_en   (set_en),
        .set_preg (rename_prd),
        .clr_en   (wb_valid),
        .clr_preg (wb_preg),
        .rd_preg0 (rename_prs1),
        .rd_preg1 (rename_prs2),
        .rd_busy0 (busy1),
        .rd_busy1 (busy2)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_valid  <= 1'b0;
            h_fu        <= FU_ALU;
            h_prs1      <= '0;
            h_prs2      <= '0;
            h_prd       <= '0;
            h_old_prd   <= '0;
            h_rob_tag   <= '0;
            h_reg_write <= 1'b0;
            h_prs1_rdy  <= 1'b0;
            h_prs2_rdy  <= 1'b0;
        end else if (branch_mispredict) begin
            hold_valid <= 1'b0;
        end else if (accept) begin
            hold_valid  <= 1'b1;
            h_fu        <= fu_type_e'(rename_fu_type);
            h_prs1      <= rename_prs1;
            h_prs2      <= rename_prs2;
            h_prd       <= rename_prd;
            h_old_prd   <= rename_old_prd;
            h_rob_tag   <= rename_rob_tag;
            h_reg_write <= rename_reg_write;
            h_prs1_rdy  <= !busy1 || (rename_prs1 == '0);
            h_prs2_rdy  <= !busy2 || (rename_prs2 == '0);
        end else if (hold_valid) begin
            if (fire) hold_valid <= 1'b0;
            // Wakeup of the waiting instruction's sources by the result broadcast.
            if (wb_valid && wb_preg == h_prs1) h_prs1_rdy <= 1'b1;
            if (wb_valid && wb_preg == h_prs2) h_prs2_rdy <= 1'b1;
        end
    end

    assign rs_alu_valid    = fire && (h_fu == FU_ALU);
    assign rs_lsu_valid    = fire && (h_fu == FU_LSU);
    assign rs_bru_valid    = fire && (h_fu == FU_BRU);
    assign rob_alloc_valid = fire;

    assign out_prs1      = h_prs1;
    assign out_prs2      = h_prs2;
    assign out_prd       = h_prd;
    assign out_rob_tag   = h_rob_tag;
    assign out_prs1_rdy  = h_prs1_rdy;
    assign out_prs2_rdy  = h_prs2_rdy;
    assign out_reg_write = h_reg_write;
    assign rob_old_prd   = h_old_prd;

endmodule

// File: tb/tb_dispatch_stage.sv
// Directed bench for dispatch_stage: per-cycle vector table plus hand-written
// reset sequences, all expected values computed by hand.
module tb_dispatch_stage;

    logic       clk = 1'b0;
    logic       reset;
    logic       rename_valid;
    logic [6:0] rename_prs1, rename_prs2, rename_prd, rename_old_prd;
    logic [3:0] rename_rob_tag;
    logic       rename_reg_write;
    logic [1:0] rename_fu_type;
    logic       dispatch_ready;
    logic       rs_alu_valid, rs_lsu_valid, rs_bru_valid;
    logic       rs_alu_ready, rs_lsu_ready, rs_bru_ready;
    logic [6:0] out_prs1, out_prs2, out_prd;
    logic [3:0] out_rob_tag;
    logic       out_prs1_rdy, out_prs2_rdy, out_reg_write;
    logic       rob_alloc_valid;
    logic [6:0] rob_old_prd;
    logic       rob_full;
    logic       wb_valid;
    logic [6:0] wb_preg;
    logic       branch_mispredict;

    dispatch_stage dut (
        .clk(clk), .reset(reset),
        .rename_valid(rename_valid), .rename_prs1(rename_prs1), .rename_prs2(rename_prs2),
        .rename_prd(rename_prd), .rename_old_prd(rename_old_prd),
        .rename_rob_tag(rename_rob_tag), .rename_reg_write(rename_reg_write),
        .rename_fu_type(rename_fu_type), .dispatch_ready(dispatch_ready),
        .rs_alu_valid(rs_alu_valid), .rs_lsu_valid(rs_lsu_valid), .rs_bru_valid(rs_bru_valid),
        .rs_alu_ready(rs_alu_ready), .rs_lsu_ready(rs_lsu_ready), .rs_bru_ready(rs_bru_ready),
        .out_prs1(out_prs1), .out_prs2(out_prs2), .out_prd(out_prd),
        .out_rob_tag(out_rob_tag), .out_prs1_rdy(out_prs1_rdy), .out_prs2_rdy(out_prs2_rdy),
        .out_reg_write(out_reg_write), .rob_alloc_valid(rob_alloc_valid),
        .rob_old_prd(rob_old_prd), .rob_full(rob_full),
        .wb_valid(wb_valid), .wb_preg(wb_preg), .branch_mispredict(branch_mispredict)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [1:0] fu;
        logic [6:0] prs1, prs2, prd;
        logic       wr;
        logic [2:0] rsr;   // {alu, lsu, bru} ready
        logic       full;
        logic       wbv;
        logic [6:0] wbp;
        logic       misp;
        logic [13:0] exp;  // {dispatch_ready, alu_v, lsu_v, bru_v, rob_alloc, out_prs1, rdy1, rdy2}
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic void add(logic v, logic [1:0] fu, logic [6:0] p1, logic [6:0] p2,
                                logic [6:0] pd, logic wr, logic [2:0] rsr, logic full,
                                logic wbv, logic [6:0] wbp, logic misp,
                                logic e_rdy, logic [2:0] e_rs, logic e_rob,
                                logic [6:0] e_p1, logic e_r1, logic e_r2);
        vec_t t;
        t.v = v; t.fu = fu; t.prs1 = p1; t.prs2 = p2; t.prd = pd; t.wr = wr;
        t.rsr = rsr; t.full = full; t.wbv = wbv; t.wbp = wbp; t.misp = misp;
        t.exp = {e_rdy, e_rs, e_rob, e_p1, e_r1, e_r2};
        tbl.push_back(t);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        rename_valid = 0; rename_prs1 = 0; rename_prs2 = 0; rename_prd = 0;
        rename_old_prd = 0; rename_rob_tag = 0; rename_reg_write = 0; rename_fu_type = 0;
        rs_alu_ready = 1; rs_lsu_ready = 1; rs_bru_ready = 1; rob_full = 0;
        wb_valid = 0; wb_preg = 0; branch_mispredict = 0;
    endtask

    logic [13:0] act;

    initial begin
        // cycle-by-cycle scenario: RAW dependency, LSU stall, ROB full, ROB-only,
        // set-vs-clear race, mispredict, back-to-back
        add(1,0, 1, 2,40,1,3'b111,0,0, 0,0, 1,3'b000,0,  0,0,0);
        add(1,0,40, 3,41,1,3'b111,0,0, 0,0, 1,3'b100,1,  1,1,1);
        add(0,0, 0, 0, 0,0,3'b011,0,0, 0,0, 0,3'b000,0, 40,0,1);
        add(0,0, 0, 0, 0,0,3'b011,0,1,40,0, 0,3'b000,0, 40,0,1);
        add(0,0, 0, 0, 0,0,3'b111,0,0, 0,0, 1,3'b100,1, 40,1,1);
        add(1,1, 0,41, 0,0,3'b101,0,0, 0,0, 1,3'b000,0, 40,1,1);
        add(1,0,11,12,42,1,3'b101,0,0, 0,0, 0,3'b000,0,  0,1,0);
        add(1,0,11,12,42,1,3'b101,0,0, 0,0, 0,3'b000,0,  0,1,0);
        add(1,0,11,12,42,1,3'b101,0,0, 0,0, 0,3'b000,0,  0,1,0);
        add(0,0, 0, 0, 0,0,3'b111,0,0, 0,0, 1,3'b010,1,  0,1,0);
        add(1,2, 5, 6, 0,0,3'b111,0,0, 0,0, 1,3'b000,0,  0,1,0);
        add(0,0, 0, 0, 0,0,3'b111,1,0, 0,0, 0,3'b000,0,  5,1,1);
        add(0,0, 0, 0, 0,0,3'b111,0,0, 0,0, 1,3'b001,1,  5,1,1);
        add(1,3, 7, 8,43,1,3'b111,0,0, 0,0, 1,3'b000,0,  5,1,1);
        add(0,0, 0, 0, 0,0,3'b000,0,0, 0,0, 1,3'b000,1,  7,1,1);
        add(1,0, 0, 9,50,1,3'b111,0,1,50,0, 1,3'b000,0,  7,1,1);
        add(1,0,50, 0, 0,0,3'b011,0,0, 0,0, 0,3'b000,0,  0,1,1);
        add(1,0,50, 0,45,1,3'b111,0,0, 0,0, 1,3'b100,1,  0,1,1);
        add(0,0, 0, 0, 0,0,3'b011,0,0, 0,0, 0,3'b000,0, 50,0,1);
        add(1,0, 0, 0,44,1,3'b111,0,0, 0,1, 0,3'b000,0, 50,0,1);
        add(0,0, 0, 0, 0,0,3'b111,0,0, 0,0, 1,3'b000,0, 50,0,1);
        add(1,0,50,45, 0,0,3'b111,0,0, 0,0, 1,3'b000,0, 50,0,1);
        add(0,0, 0, 0, 0,0,3'b111,0,0, 0,0, 1,3'b100,1, 50,0,0);
        add(1,0,10, 0, 0,0,3'b111,0,0, 0,0, 1,3'b000,0, 50,0,0);
        add(1,0,11, 0, 0,0,3'b111,0,0, 0,0, 1,3'b100,1, 10,1,1);
        add(1,0,12, 0, 0,0,3'b111,0,0, 0,0, 1,3'b100,1, 11,1,1);
        add(0,0, 0, 0, 0,0,3'b111,0,0, 0,0, 1,3'b100,1, 12,1,1);
        add(0,0, 0, 0, 0,0,3'b111,0,0, 0,0, 1,3'b000,0, 12,1,1);

        idle_inputs();
        reset = 1;
        #12;
        chk("reset_dispatch_ready", 32'(dispatch_ready), 1);
        chk("reset_valids", {28'd0, rs_alu_valid, rs_lsu_valid, rs_bru_valid, rob_alloc_valid}, 0);
        chk("reset_payload", {7'd0, out_prs1, out_prs2, out_prd, out_rob_tag}, 0);
        chk("reset_old_prd", 32'(rob_old_prd), 0);
        @(negedge clk);
        reset = 0;

        foreach (tbl[i]) begin
            @(posedge clk);
            #1;
            rename_valid = tbl[i].v; rename_fu_type = tbl[i].fu;
            rename_prs1 = tbl[i].prs1; rename_prs2 = tbl[i].prs2; rename_prd = tbl[i].prd;
            rename_reg_write = tbl[i].wr; rename_old_prd = 0; rename_rob_tag = 4'(i);
            {rs_alu_ready, rs_lsu_ready, rs_bru_ready} = tbl[i].rsr;
            rob_full = tbl[i].full; wb_valid = tbl[i].wbv; wb_preg = tbl[i].wbp;
            branch_mispredict = tbl[i].misp;
            #3;
            act = {dispatch_ready, rs_alu_valid, rs_lsu_valid, rs_bru_valid, rob_alloc_valid,
                   out_prs1, out_prs1_rdy, out_prs2_rdy};
            chk($sformatf("vec%0d", i), 32'(act), 32'(tbl[i].exp));
        end

        // payload capture, then reset in the middle of a stall
        @(posedge clk);
        #1;
        idle_inputs();
        rename_valid = 1; rename_fu_type = 0; rename_prs1 = 45; rename_prs2 = 3;
        rename_prd = 46; rename_old_prd = 33; rename_rob_tag = 5; rename_reg_write = 1;
        rs_alu_ready = 0;
        @(posedge clk);
        #1;
        rename_valid = 0;
        #3;
        chk("held_prd", 32'(out_prd), 46);
        chk("held_old_prd", 32'(rob_old_prd), 33);
        chk("held_rob_tag", 32'(out_rob_tag), 5);
        chk("held_stall", {30'd0, dispatch_ready, out_prs1_rdy}, 0);
        #1;
        reset = 1;
        #1;
        rs_alu_ready = 1;
        #1;
        chk("midreset_no_fire", {30'd0, rs_alu_valid, rob_alloc_valid}, 0);
        chk("midreset_ready", 32'(dispatch_ready), 1);
        chk("midreset_payload", 32'(out_prd), 0);
        @(negedge clk);
        reset = 0;
        @(posedge clk);
        #1;
        chk("after_reset_no_fire", 32'(rob_alloc_valid), 0);
        // busy table was wiped by reset, so 45 reads ready again
        rename_valid = 1; rename_prs1 = 45; rename_prs2 = 46; rename_prd = 0;
        rename_reg_write = 0; rs_alu_ready = 0;
        @(posedge clk);
        #1;
        rename_valid = 0;
        #3;
        chk("busy_cleared_by_reset", {30'd0, out_prs1_rdy, out_prs2_rdy}, 2'b11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
